line_cmd_feeder: RTL and testbench
==================================

Name: line_cmd_feeder

Overview:
- Command front-end directly upstream of the line engine.
- Pops 32-bit command words from a first-word-fall-through (FWFT) command FIFO that the processor/DMA fills. Decodes line-draw and frame-base commands.
- Sequences the line engine's color/point0/point1/trigger inputs one cycle at a time. Waits for each line to finish before fetching the next command, so lines never overlap.

Parameters:
- OPC_NOP, 8'h00, opcode consumed with no action
- OPC_FB, 8'h01, set-frame-base opcode; the next word is the base
- OPC_LINE, 8'h02, line opcode; word0[23:0] is color, followed by two point words
- FB_RESET, 32'h1000_0000, LE_frame_base value after reset
- CNT_W, 16, width of lines_done

Ports:
- clk  in  1  system clock
- rst_n  in  1  reset; one clock; reset is synchronous and active-low
- cmd_dout  in  32  FIFO head word; valid whenever cmd_empty=0
- cmd_empty  in  1  FIFO empty
- cmd_rd_en  out  1  pop strobe; asserted combinationally, never while cmd_empty=1
- LE_ready  in  1  line engine idle/setup indicator
- LE_color  out  32  {8'b0, color[23:0]}
- LE_point  out  20  {x[9:0], y[9:0]}
- LE_color_valid  out  1  one-cycle strobe
- LE_point0_valid  out  1  one-cycle strobe
- LE_point1_valid  out  1  one-cycle strobe
- LE_trigger  out  1  one-cycle strobe
- LE_frame_base  out  32  registered frame-buffer base
- busy  out  1  high whenever state is not IDLE
- lines_done  out  CNT_W  count of completed lines; wraps
- bad_opcode  out  1  sticky error flag; cleared only by reset

Behaviour:
- Reset (rst_n=0 at a clk edge) values:
  - state=IDLE; all strobes=0; LE_color=0; LE_point=0; LE_frame_base=FB_RESET; lines_done=0; bad_opcode=0; busy=0.
  - Reset mid-command abandons the command. Words already popped are lost; the FIFO is not rewound.
- Outputs:
  - Strobes and LE_point/LE_color are Moore outputs decoded from the state register.
  - Each strobe is high for exactly one cycle.
  - LE_point=0 and LE_color=0 outside their send states.
- States and transitions:
  - IDLE: if !cmd_empty, pop the word and decode cmd_dout[31:24]:
    - OPC_LINE: latch color=cmd_dout[23:0], go to FETCH_P0.
    - OPC_FB: go to FETCH_FB.
    - OPC_NOP: stay in IDLE.
    - Any other opcode: set bad_opcode, stay in IDLE.
  - FETCH_FB: when !cmd_empty, pop the word, load LE_frame_base=cmd_dout, go to IDLE. Frame base therefore changes only between lines.
  - FETCH_P0: when !cmd_empty, pop the word, latch p0=cmd_dout[19:0], go to FETCH_P1. Bits [31:20] are ignored.
  - FETCH_P1: when !cmd_empty, pop the word, latch p1=cmd_dout[19:0], go to WAIT_READY.
  - WAIT_READY: go to SEND_COLOR when LE_ready=1. This covers the engine still busy after reset.
  - SEND_COLOR: LE_color_valid=1, LE_color={8'b0,color}. Next state is SEND_P0.
  - SEND_P0: LE_point0_valid=1, LE_point=p0. Next state is SEND_P1.
  - SEND_P1: LE_point1_valid=1, LE_point=p1. Next state is SEND_TRIG.
  - SEND_TRIG: LE_trigger=1. Next state is WAIT_BUSY.
  - WAIT_BUSY: wait for LE_ready=0, i.e. the engine has accepted the trigger. No timeout.
  - WAIT_DONE: wait for LE_ready=1. On that cycle lines_done increments (0xFFFF wraps to 0), then go to IDLE.
- Stall and boundary rules:
  - An empty FIFO in any FETCH state holds the state with cmd_rd_en=0.
  - At most one pop per cycle.
  - The earliest next pop is the cycle after return to IDLE.
- Coordinate handling:
  - Coordinates pass through unchecked: no clipping and no swap. The engine performs ordering.
  - A degenerate line (p0==p1) is sent normally.
- Latency:
  - Last point word popped to LE_color_valid = 2 cycles, with LE_ready already high.
  - Color strobe to trigger = 3 cycles.

Test Plan:
- Reset, then FIFO=[0x02FF0000, {x=10,y=20}, {x=50,y=30}] with LE model ready → expect:
  - LE_color_valid with LE_color=0x00FF0000;
  - point0 strobe with LE_point=0x02814, then point1 strobe with LE_point=0x0C81E;
  - trigger on the next cycle;
  - lines_done=1 after the model releases LE_ready.
- FIFO=[0x01000000, 0x10400000, line cmd] → expect LE_frame_base=0x10400000 before the color strobe; reset value 0x10000000 before that.
- Empty FIFO inserted between each word of a line command → cmd_rd_en never high while empty; strobe order unchanged; no duplicate pops.
- Back-to-back line commands with LE_ready held low for 40 cycles after the first trigger → second color strobe only after LE_ready returns; lines_done=2 at the end.
- Opcodes 0x00 then 0x7A → the NOP is consumed silently; bad_opcode rises after 0x7A and stays high until rst_n=0.
- rst_n=0 asserted in SEND_P0 → all strobes low next cycle; busy=0; the following command executes cleanly.

Source files
------------

// File: rtl/line_cmd_feeder.sv
// Command front-end for the line engine: pops FWFT command words, decodes
// frame-base and line commands, and strobes color/points/trigger one line at a time.
module line_cmd_feeder #(
  parameter logic [7:0]  OPC_NOP  = 8'h00,
  parameter logic [7:0]  OPC_FB   = 8'h01,
  parameter logic [7:0]  OPC_LINE = 8'h02,
  parameter logic [31:0] FB_RESET = 32'h1000_0000,
  parameter int          CNT_W    = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [31:0]      cmd_dout,
  input  logic             cmd_empty,
  output logic             cmd_rd_en,
  input  logic             LE_ready,
  output logic [31:0]      LE_color,
  output logic [19:0]      LE_point,
  output logic             LE_color_valid,
  output logic             LE_point0_valid,
  output logic             LE_point1_valid,
  output logic             LE_trigger,
  output logic [31:0]      LE_frame_base,
  output logic             busy,
  output logic [CNT_W-1:0] lines_done,
  output logic             bad_opcode
);

  typedef enum logic [3:0] {
    IDLE, FETCH_FB, FETCH_P0, FETCH_P1, WAIT_READY,
    SEND_COLOR, SEND_P0, SEND_P1, SEND_TRIG, WAIT_BUSY, WAIT_DONE
  } state_e;

  state_e           state_q, state_d;
  logic [23:0]      color_q, color_d;
  logic [19:0]      p0_q, p0_d;
  logic [19:0]      p1_q, p1_d;
  logic [31:0]      fb_q, fb_d;
  logic [CNT_W-1:0] lines_q, lines_d;
  logic             bad_q, bad_d;
  logic             wordAvail;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      color_q <= '0;
      p0_q    <= '0;
      p1_q    <= '0;
      fb_q    <= FB_RESET;
      lines_q <= '0;
      bad_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      color_q <= color_d;
      p0_q    <= p0_d;
      p1_q    <= p1_d;
      fb_q    <= fb_d;
      lines_q <= lines_d;
      bad_q   <= bad_d;
    end
  end

  // Popping is suppressed while reset is asserted so no word is lost to a dead cycle.
  assign wordAvail = rst_n && !cmd_empty;

  always_comb begin
    state_d   = state_q;
    color_d   = color_q;
    p0_d      = p0_q;
    p1_d      = p1_q;
    fb_d      = fb_q;
    lines_d   = lines_q;
    bad_d     = bad_q;
    cmd_rd_en = 1'b0;
    case (state_q)
      IDLE: begin
        if (wordAvail) begin
          cmd_rd_en = 1'b1;
          case (cmd_dout[31:24])
            OPC_LINE: begin
              color_d = cmd_dout[23:0];
              state_d = FETCH_P0;
            end
            OPC_FB:  state_d = FETCH_FB;
            OPC_NOP: state_d = IDLE;
            default: bad_d = 1'b1;
          endcase
        end
      end
      FETCH_FB: begin
        if (wordAvail) begin
          cmd_rd_en = 1'b1;
          fb_d      = cmd_dout;
          state_d   = IDLE;
        end
      end
      FETCH_P0: begin
        if (wordAvail) begin
          cmd_rd_en = 1'b1;
          p0_d      = cmd_dout[19:0];
          state_d   = FETCH_P1;
        end
      end
      FETCH_P1: begin
        if (wordAvail) begin
          cmd_rd_en = 1'b1;
          p1_d      = cmd_dout[19:0];
          state_d   = WAIT_READY;
        end
      end
      WAIT_READY: if (LE_ready) state_d = SEND_COLOR;
      SEND_COLOR: state_d = SEND_P0;
      SEND_P0:    state_d = SEND_P1;
      SEND_P1:    state_d = SEND_TRIG;
      SEND_TRIG:  state_d = WAIT_BUSY;
      WAIT_BUSY:  if (!LE_ready) state_d = WAIT_DONE;
      WAIT_DONE: begin
        if (LE_ready) begin
          lines_d = lines_q + {{(CNT_W-1){1'b0}}, 1'b1};
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    LE_color        = '0;
    LE_point        = '0;
    LE_color_valid  = 1'b0;
    LE_point0_valid = 1'b0;
    LE_point1_valid = 1'b0;
    LE_trigger      = 1'b0;
    case (state_q)
      SEND_COLOR: begin
        LE_color_valid = 1'b1;
        LE_color       = {8'b0, color_q};
      end
      SEND_P0: begin
        LE_point0_valid = 1'b1;
        LE_point        = p0_q;
      end
      SEND_P1: begin
        LE_point1_valid = 1'b1;
        LE_point        = p1_q;
      end
      SEND_TRIG: LE_trigger = 1'b1;
      default: ;
    endcase
  end

  assign LE_frame_base = fb_q;
  assign busy          = (state_q != IDLE);
  assign lines_done    = lines_q;
  assign bad_opcode    = bad_q;

endmodule

// File: tb/tb_line_cmd_feeder.sv
// Self-checking bench: FIFO and line-engine models drive the feeder; a command-level
// scoreboard predicts every line's strobe burst, frame base, counts and error flag.
module tb_line_cmd_feeder;

  localparam logic [31:0] FB_RESET = 32'h1000_0000;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] cmd_dout;
  logic        cmd_empty;
  logic        cmd_rd_en;
  logic        LE_ready;
  logic [31:0] LE_color;
  logic [19:0] LE_point;
  logic        LE_color_valid, LE_point0_valid, LE_point1_valid, LE_trigger;
  logic [31:0] LE_frame_base;
  logic        busy;
  logic [15:0] lines_done;
  logic        bad_opcode;

  always #5 clk = ~clk;

  line_cmd_feeder dut (
    .clk(clk), .rst_n(rst_n), .cmd_dout(cmd_dout), .cmd_empty(cmd_empty),
    .cmd_rd_en(cmd_rd_en), .LE_ready(LE_ready), .LE_color(LE_color),
    .LE_point(LE_point), .LE_color_valid(LE_color_valid),
    .LE_point0_valid(LE_point0_valid), .LE_point1_valid(LE_point1_valid),
    .LE_trigger(LE_trigger), .LE_frame_base(LE_frame_base), .busy(busy),
    .lines_done(lines_done), .bad_opcode(bad_opcode)
  );

  typedef struct {
    logic [31:0] color;
    logic [19:0] p0;
    logic [19:0] p1;
    logic [31:0] fb;
  } lineRec_t;

  typedef struct {
    logic [31:0] w0, w1, w2;
    logic [31:0] expColor;
    logic [19:0] expP0, expP1;
  } lineVec_t;

  logic [31:0] fifoQ[$];
  lineRec_t    expQ[$];
  lineRec_t    cur;
  int          errors = 0, checks = 0;
  int          cycleNo = 0, lastPopCycle = -100, phase = 0;
  int          gapPct = 0, busyLen = 3, leBusyCnt = 0, holdoff = 0;
  bit          inReset = 1'b0, checkLatency = 1'b1;
  logic [31:0] modelFb = FB_RESET;
  bit          modelBad = 1'b0;
  int          modelLines = 0;

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cycleNo);
    end
  endtask

  task automatic pushLineExp(input logic [31:0] w0, w1, w2, input logic [31:0] ec,
                             input logic [19:0] e0, e1);
    lineRec_t r;
    fifoQ.push_back(w0);
    fifoQ.push_back(w1);
    fifoQ.push_back(w2);
    r.color = ec; r.p0 = e0; r.p1 = e1; r.fb = modelFb;
    expQ.push_back(r);
    modelLines++;
  endtask

  task automatic pushLine(input logic [23:0] color, input logic [31:0] w1, w2);
    pushLineExp({8'h02, color}, w1, w2, {8'h00, color}, w1[19:0], w2[19:0]);
  endtask

  task automatic pushFb(input logic [31:0] base);
    logic [31:0] r = $urandom;
    fifoQ.push_back({8'h01, r[23:0]});
    fifoQ.push_back(base);
    modelFb = base;
  endtask

  task automatic pushOther(input logic [7:0] op);
    logic [31:0] r = $urandom;
    fifoQ.push_back({op, r[23:0]});
    if (op != 8'h00) modelBad = 1'b1;
  endtask

  // Per-cycle protocol checks against the expected line stream.
  task automatic monitor();
    logic [3:0] str;
    logic [3:0] expStr;
    str = {LE_color_valid, LE_point0_valid, LE_point1_valid, LE_trigger};
    if (cmd_empty) checkOutput("rdWhileEmpty", cmd_rd_en, 0);
    if (phase == 0) begin
      if (str === 4'b1000) begin
        checks++;
        if (expQ.size() == 0) begin
          errors++;
          $display("[TB] FAIL unexpectedLine: got color strobe, expected none (cycle %0d)", cycleNo);
        end else begin
          cur = expQ.pop_front();
          checkOutput("color", LE_color, cur.color);
          checkOutput("frameBaseAtColor", LE_frame_base, cur.fb);
          checkOutput("engineReadyAtColor", LE_ready, 1);
          if (checkLatency) checkOutput("popToColor", 64'(cycleNo - lastPopCycle), 2);
          phase = 1;
        end
      end else checkOutput("noStrobe", str, 0);
    end else begin
      expStr = 4'b1000 >> phase;
      checkOutput("strobeOrder", str, expStr);
      if (phase == 1) checkOutput("point0", LE_point, cur.p0);
      if (phase == 2) checkOutput("point1", LE_point, cur.p1);
      phase = (phase == 3) ? 0 : phase + 1;
    end
    if (str !== 4'b0000) checkOutput("busyWhileSending", busy, 1);
    if (LE_color_valid !== 1'b1) checkOutput("colorZero", LE_color, 0);
    if (LE_point0_valid !== 1'b1 && LE_point1_valid !== 1'b1) checkOutput("pointZero", LE_point, 0);
  endtask

  // One clock: drive inputs after the falling edge, sample, then advance the models.
  task automatic applyStimulus();
    logic rd, trig, emp;
    if (inReset || fifoQ.size() == 0 || $urandom_range(99) < gapPct) begin
      cmd_empty = 1'b1;
      cmd_dout  = $urandom;
    end else begin
      cmd_empty = 1'b0;
      cmd_dout  = fifoQ[0];
    end
    LE_ready = (leBusyCnt == 0 && holdoff == 0);
    #1;
    rd = cmd_rd_en; trig = LE_trigger; emp = cmd_empty;
    if (!inReset) monitor();
    @(posedge clk);
    if (rd === 1'b1 && !emp) begin
      void'(fifoQ.pop_front());
      lastPopCycle = cycleNo;
    end
    if (trig === 1'b1) leBusyCnt = busyLen;
    else if (leBusyCnt > 0) leBusyCnt--;
    if (holdoff > 0) holdoff--;
    cycleNo++;
    @(negedge clk);
  endtask

  task automatic doReset();
    inReset = 1'b1;
    rst_n = 1'b0;
    applyStimulus();
    rst_n = 1'b1;
    inReset = 1'b0;
    expQ.delete();
    phase = 0; modelFb = FB_RESET; modelBad = 1'b0; modelLines = 0; leBusyCnt = 0;
    checkOutput("rstStrobes", {LE_color_valid, LE_point0_valid, LE_point1_valid, LE_trigger}, 0);
    checkOutput("rstBusy", busy, 0);
    checkOutput("rstColor", LE_color, 0);
    checkOutput("rstPoint", LE_point, 0);
    checkOutput("rstFrameBase", LE_frame_base, FB_RESET);
    checkOutput("rstLines", lines_done, 0);
    checkOutput("rstBad", bad_opcode, 0);
  endtask

  task automatic drain(input int budget);
    int n = 0;
    while ((fifoQ.size() != 0 || busy !== 1'b0 || expQ.size() != 0 || phase != 0) && n < budget) begin
      applyStimulus();
      n++;
    end
    checks++;
    if (n >= budget) begin
      errors++;
      $display("[TB] FAIL drainTimeout: got %0d cycles, expected under %0d", n, budget);
    end
    checkOutput("linesDone", lines_done, 16'(modelLines));
    checkOutput("badOpcode", bad_opcode, modelBad);
    checkOutput("idleAfterDrain", busy, 0);
  endtask

  lineVec_t vecs[5];

  initial begin
    vecs[0] = '{32'h02FF0000, 32'h00002814, 32'h0000C81E, 32'h00FF0000, 20'h02814, 20'h0C81E};
    vecs[1] = '{32'h02123456, 32'hFFF003FF, 32'hFFFFFC00, 32'h00123456, 20'h003FF, 20'hFFC00};
    vecs[2] = '{32'h02000001, 32'h000ABCDE, 32'h000ABCDE, 32'h00000001, 20'hABCDE, 20'hABCDE};
    vecs[3] = '{32'h02FFFFFF, 32'h00000000, 32'h000FFFFF, 32'h00FFFFFF, 20'h00000, 20'hFFFFF};
    vecs[4] = '{32'h02ABCDEF, 32'hA5512345, 32'h3C0F0F0F, 32'h00ABCDEF, 20'h12345, 20'hF0F0F};

    doReset();
    for (int i = 0; i < 5; i++) begin
      pushLineExp(vecs[i].w0, vecs[i].w1, vecs[i].w2, vecs[i].expColor, vecs[i].expP0, vecs[i].expP1);
      drain(200);
    end

    // Frame base update ahead of a line
    doReset();
    pushFb(32'h1040_0000);
    pushLine(24'h00BEEF, 32'h0000_0401, 32'h0000_0802);
    drain(200);
    checkOutput("frameBaseAfter", LE_frame_base, 32'h1040_0000);

    // Empty gaps between command words
    gapPct = 60;
    pushLine(24'h111111, 32'h0001_1111, 32'h0002_2222);
    pushLine(24'h222222, 32'h0003_3333, 32'h0004_4444);
    drain(1000);
    gapPct = 0;

    // Back-to-back lines with a slow engine
    doReset();
    busyLen = 40;
    pushLine(24'h0000AA, 32'h0000_0001, 32'h0000_0002);
    pushLine(24'h0000BB, 32'h0000_0003, 32'h0000_0004);
    drain(500);
    busyLen = 3;

    // NOP then an unknown opcode; error flag is sticky
    doReset();
    pushOther(8'h00);
    drain(50);
    pushOther(8'h7A);
    drain(50);
    pushLine(24'h123123, 32'h0000_5555, 32'h0000_6666);
    drain(200);

    // Reset in SEND_P0, then a line with the engine busy after reset
    pushLine(24'h0F0F0F, 32'h0000_7777, 32'h0000_8888);
    for (int n = 0; n < 100 && LE_point0_valid !== 1'b1; n++) applyStimulus();
    checkOutput("reachedSendP0", LE_point0_valid, 1);
    doReset();
    holdoff = 15;
    checkLatency = 1'b0;
    pushLine(24'h00C0DE, 32'h0000_9999, 32'h0000_AAAA);
    drain(300);
    checkLatency = 1'b1;

    // Randomized command stream
    doReset();
    for (int i = 0; i < 40; i++) begin
      int kind = $urandom_range(99);
      logic [31:0] r0 = $urandom;
      gapPct  = $urandom_range(40);
      busyLen = $urandom_range(1, 10);
      if (kind < 60) pushLine(r0[23:0], $urandom, $urandom);
      else if (kind < 75) pushFb($urandom);
      else if (kind < 90) pushOther(8'h00);
      else pushOther(8'($urandom_range(3, 255)));
      if (i % 8 == 7) drain(3000);
    end
    drain(3000);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
